// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op encodings mirror funct3 so the instruction field casts straight into opT.
package muldiv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [4:0]  ITER_LAST = 5'd31;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } opT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateT;

    function automatic logic isDivOp(opT op);
        return op[2];
    endfunction

    // Remainder ops are the upper pair of the divide group.
    function automatic logic isRemOp(opT op);
        return op[2] & op[1];
    endfunction

    function automatic logic signedA(opT op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic signedB(opT op);
        return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    endfunction

    function automatic logic [31:0] absVal(logic [31:0] v, logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One shift-add multiply or restoring-divide step per enable on a shared
// 64-bit register; accNext exposes the post-step value for result capture.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [63:0]     loadVal,
    input  logic            en,
    input  logic            isDiv,
    input  logic [XLEN-1:0] opnd,
    output logic [63:0]     accNext
);

    logic [63:0] acc;
    logic [33:0] lhs;
    logic [33:0] rhs;
    logic [33:0] sum;

    // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {partial, multiplier}.
    always_comb begin
        lhs     = '0;
        rhs     = '0;
        sum     = '0;
        accNext = acc;
        if (isDiv) begin
            lhs = {1'b0, acc[63:31]};
            rhs = {2'b00, opnd};
            sum = lhs - rhs;
            if (sum[33]) begin
                accNext = {acc[62:0], 1'b0};
            end else begin
                accNext = {sum[31:0], acc[30:0], 1'b1};
            end
        end else begin
            lhs     = {2'b00, acc[63:32]};
            rhs     = acc[0] ? {2'b00, opnd} : '0;
            sum     = lhs + rhs;
            accNext = {sum[32:0], acc[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= loadVal;
        end else if (en) begin
            acc <= accNext;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: 32-step multiply/divide with pipeline stall,
// RISC-V divide special cases resolved in one cycle, and a one-cycle done pulse.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wr_addr
);

    // Handshake: start is EX's valid and is held while stall=1; stall acts as
    // not-ready. A command is accepted when IDLE & start & ~flush, and its
    // result appears for exactly one cycle with done=1, during which stall=0
    // so the instruction leaves EX; start seen in DONE is never re-accepted.

    stateT           state;
    stateT           stateNext;
    opT              opIn;
    opT              opReg;
    logic [4:0]      rdReg;
    logic [4:0]      cnt;
    logic [XLEN-1:0] magB;
    logic            negRes;

    logic            signA;
    logic            signB;
    logic [XLEN-1:0] magAIn;
    logic [XLEN-1:0] magBIn;
    logic            negIn;
    logic            divZero;
    logic            divOvf;
    logic            special;
    logic [XLEN-1:0] specialVal;

    logic            accept;
    logic            iterEn;
    logic            lastIter;
    logic            iterIsDiv;
    logic [63:0]     accNext;
    logic [63:0]     prodFix;
    logic [XLEN-1:0] quotFix;
    logic [XLEN-1:0] remFix;
    logic [XLEN-1:0] calcVal;

    always_comb begin
        opIn    = opT'(funct3);
        signA   = signedA(opIn) & rs1_val[XLEN-1];
        signB   = signedB(opIn) & rs2_val[XLEN-1];
        magAIn  = absVal(rs1_val, signA);
        magBIn  = absVal(rs2_val, signB);
        negIn   = isRemOp(opIn) ? signA : (signA ^ signB);
        divZero = isDivOp(opIn) && (rs2_val == '0);
        divOvf  = (opIn inside {OP_DIV, OP_REM}) && (rs1_val == INT_MIN) && (rs2_val == '1);
        special = divZero | divOvf;
        if (divZero) begin
            specialVal = isRemOp(opIn) ? rs1_val : DIV0_QUOT;
        end else begin
            specialVal = isRemOp(opIn) ? '0 : INT_MIN;
        end
    end

    assign accept    = (state == IDLE) && start && !flush;
    assign iterEn    = (state == CALC) && !flush;
    assign lastIter  = (cnt == ITER_LAST);
    assign iterIsDiv = isDivOp(opReg);

    muldiv_iter uIter (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .loadVal ({{XLEN{1'b0}}, magAIn}),
        .en      (iterEn),
        .isDiv   (iterIsDiv),
        .opnd    (magB),
        .accNext (accNext)
    );

    // Sign fix and high/low selection on the value the final step produces.
    always_comb begin
        prodFix = negRes ? -accNext : accNext;
        quotFix = negRes ? -accNext[31:0] : accNext[31:0];
        remFix  = negRes ? -accNext[63:32] : accNext[63:32];
        case (opReg)
            OP_MUL:                       calcVal = prodFix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calcVal = prodFix[63:32];
            OP_DIV, OP_DIVU:              calcVal = quotFix;
            default:                      calcVal = remFix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        done      = 1'b0;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    stall = start;
                    if (start) begin
                        stateNext = special ? DONE : CALC;
                    end
                end
                CALC: begin
                    stall = 1'b1;
                    if (lastIter) begin
                        stateNext = DONE;
                    end
                end
                DONE: begin
                    done      = 1'b1;
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opReg   <= OP_MUL;
            rdReg   <= '0;
            cnt     <= '0;
            magB    <= '0;
            negRes  <= 1'b0;
            result  <= '0;
            wr_addr <= '0;
        end else if (accept) begin
            opReg  <= opIn;
            rdReg  <= rd_addr;
            magB   <= magBIn;
            negRes <= negIn;
            cnt    <= '0;
            if (special) begin
                result  <= specialVal;
                wr_addr <= rd_addr;
            end
        end else if (iterEn) begin
            cnt <= cnt + 5'd1;
            if (lastIter) begin
                result  <= calcVal;
                wr_addr <= rdReg;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, flush/reset sequences and
// random ops checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wr_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] expRes;
        int          expLat;
    } vecT;

    vecT vecs[16];

    muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result),
        .wr_addr (wr_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Plain RV32M arithmetic, independent of how the unit iterates.
    function automatic logic [31:0] refModel(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = 0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: begin p = sa * sb; p = p >>> 32; end
            3'd2: begin p = sa * ub; p = p >>> 32; end
            3'd3: begin p = ua * ub; p = p >> 32; end
            3'd4: begin
                if (b == 0) p = -1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = sa;
                else p = sa / sb;
            end
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: begin
                if (b == 0) p = sa;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int refLat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    // Issues one instruction at the next negedge (cycle T), holds start like a
    // stalled pipeline, and checks stall pattern, latency, result and wr_addr.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expRes, input int expLat,
                         input string tag);
        int lat;
        bit stallErr;
        lat      = 0;
        stallErr = 0;
        @(negedge clk);
        start   = 1'b1;
        flush   = 1'b0;
        funct3  = op;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        #1;
        if (stall !== 1'b1 || done !== 1'b0) stallErr = 1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                if (stall !== 1'b0) stallErr = 1;
            end else if (stall !== 1'b1 && k < expLat) begin
                stallErr = 1;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " stall"}, {31'h0, stallErr}, 32'h0);
        if (lat != 0) begin
            check({tag, " result"}, result, expRes);
            check({tag, " wr_addr"}, {27'h0, wr_addr}, {27'h0, rd});
        end
    endtask

    initial begin
        int dones;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] held;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         33};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         5'd14, 32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0,         1};
        vecs[12] = '{3'd5, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         5'd18, 32'hFFFF_FFFB, 1};
        vecs[14] = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 33};
        vecs[15] = '{3'd4, 32'h8000_0000,  32'd1,         5'd20, 32'h8000_0000, 33};

        rst     = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'd0;
        rs1_val = '0;
        rs2_val = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset wr_addr", {27'h0, wr_addr}, 32'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].expRes, vecs[i].expLat,
                  $sformatf("vec%0d", i));
        end

        // Back-to-back DIVU with start never dropping.
        runOp(3'd5, 32'd1000, 32'd33, 5'd21, 32'd30, 33, "b2b_first");
        runOp(3'd5, 32'd1000, 32'd9, 5'd22, 32'd111, 33, "b2b_second");
        held = result;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("hold done low", {31'h0, done}, 32'h0);
        check("hold result", result, held);
        check("hold wr_addr", {27'h0, wr_addr}, 32'd22);

        // Flush ten cycles into a divide, then restart on the next cycle.
        @(negedge clk);
        start   = 1'b1;
        funct3  = 3'd5;
        rs1_val = 32'd500;
        rs2_val = 32'd3;
        rd_addr = 5'd23;
        dones   = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || stall !== 1'b1) dones++;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush pre-cycles", 32'(dones), 32'h0);
        check("flush stall", {31'h0, stall}, 32'h0);
        check("flush done", {31'h0, done}, 32'h0);
        runOp(3'd0, 32'd123, 32'd45, 5'd24, 32'd5535, 33, "after_flush");

        // Reset in the middle of a calculation.
        @(negedge clk);
        start   = 1'b1;
        funct3  = 3'd1;
        rs1_val = 32'h1234_5678;
        rs2_val = 32'h9ABC_DEF0;
        rd_addr = 5'd25;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midcalc rst done", {31'h0, done}, 32'h0);
        check("midcalc rst result", result, 32'h0);
        check("midcalc rst wr_addr", {27'h0, wr_addr}, 32'h0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        check("no done after reset", 32'(dones), 32'h0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            rd = 5'($urandom_range(0, 31));
            runOp(op, a, b, rd, refModel(op, a, b), refLat(op, a, b), $sformatf("rand%0d", i));
        end

        @(negedge clk);
        start = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the EX stage, directly downstream of the register file.
- Consumes the two register-file read values (rs1/rs2 operands) for M-extension instructions and runs a 32-iteration shift-add multiply or restoring divide.
- Stalls the pipeline while busy, then presents the result plus destination address for one cycle on the register-file write path.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
start  input  1  EX holds a valid M-extension instruction
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  32  operand A from register file Val1
rs2_val  input  32  operand B from register file Val2
rd_addr  input  5  destination register
flush  input  1  kill the in-flight operation (branch/exception)
stall  output  1  hold IF/ID/EX pipeline registers
done  output  1  result valid this cycle; one-cycle pulse
result  output  32  operation result
wr_addr  output  5  destination register for result

Behaviour:
- Reset: when rst=0, all registers clear asynchronously. State=IDLE; done=0, result=0, wr_addr=0, and all internal accumulators are 0.
- State machine has three states: IDLE, CALC, DONE.
- IDLE:
  - When start=1 and flush=0, latch funct3, rd_addr, the operand magnitudes and the result sign. Go to CALC, or to DONE for a special case.
  - Otherwise stay in IDLE.
- CALC:
  - Counter runs 0..31, one iteration per cycle.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring; shift the remainder, trial-subtract the divisor, set the quotient bit.
  - After iteration 31, go to DONE. The sign fix and high/low selection are registered into result on that transition.
- DONE: done=1 and wr_addr=latched rd. Always returns to IDLE next cycle. start is ignored in DONE, so an instruction held during stall is not re-issued.
- Latency:
  - start sampled in cycle T; done=1 in T+33 for normal ops.
  - Special-case divides (below) give done=1 in T+1.
- stall = (state==IDLE & start & ~flush) | (state==CALC). stall is low in the DONE cycle, so the instruction advances together with its result.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Output selection:
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32], after two's-complement negation when the result sign is 1.
  - Quotient sign = signA ^ signB. Remainder sign = signA.
- Special cases (RISC-V defined; no CALC):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1_val.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- flush:
  - Synchronous; highest priority after reset.
  - In any state: next state is IDLE, no done pulse, stall=0 in the flush cycle.
  - start in the same cycle is ignored.
- result and wr_addr hold their last values after done until the next completion. Consumers qualify with done.
- Register-file write enable = done. The x0 write is suppressed by the register file.
- Reset asserted mid-CALC aborts immediately. No done pulse follows reset release.

Decomposition:
- muldiv_pkg holds:
  - funct3 op enum (MUL..REMU) and the state enum (IDLE/CALC/DONE)
  - XLEN and ITER_LAST=31
  - constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000
- One sub-module, muldiv_iter: shared 64-bit shift register plus 33-bit adder/subtractor. It is parameterised by mode (mul/div) and performs one iteration per enable.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 at T -> stall high T..T+32; done only at T+33 with result=0xFFFFFFEB, wr_addr=5.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has done at T+33.
- Special cases: DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. stall high only in cycle T.
- Flush and reset:
  - flush at T+10 during CALC -> no done, stall low from T+10; new start at T+11 completes at T+44 with the correct value.
  - rst=0 mid-CALC -> done/result/wr_addr = 0 immediately.
- start held high across the whole stall, then a second back-to-back DIVU -> exactly one done per instruction, no spurious restart in DONE.
